cpu_state_dumper: RTL

//  Hardware read-back engine for Simple_Single_CPU. Counts clock cycles after reset release. At END_COUNT it freezes the CPU.
//  It then reads general registers 0..NUM_REGS-1 and data-memory words 0..NUM_MEM-1 through their read ports.

---
 rtl/cpu_state_dumper.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_state_dumper.sv
// -----------------------------------------------------------------------------
// cpu_state_dumper
//
// A synthesizable read-back engine for Simple_Single_CPU. After reset is
// released it counts END_COUNT clock edges and then freezes the CPU. It then
// reads register-file entries 0..NUM_REGS-1 and data-memory words
// 0..NUM_MEM-1 through their combinational read ports. Each word is presented
// on a valid/ready stream.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active high
//   cpu_stall_o    1 = CPU holds its PC and suppresses RF/DM writes
//   rf_addr_o      register-file read address (driven only during REG phase)
//   rf_data_i      register-file read data, combinational from rf_addr_o
//   dm_addr_o      data-memory byte address (word index * 4, MEM phase only)
//   dm_data_i      data-memory read data, combinational from dm_addr_o
//   dump_valid_o   dump word available
//   dump_ready_i   sink accepts the word on an edge with valid & ready
//   dump_data_o    dump word
//   dump_is_mem_o  0 = register word, 1 = memory word
//   dump_idx_o     register index or memory word index
//   dump_last_o    marks the final word of the dump
//   done_o         dump complete, sticky until reset
// -----------------------------------------------------------------------------
module cpu_state_dumper #(
  parameter int END_COUNT = 600,
  parameter int NUM_REGS  = 32,
  parameter int NUM_MEM   = 12,
  parameter int MEM_AW    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              cpu_stall_o,
  output logic [4:0]        rf_addr_o,
  input  logic [31:0]       rf_data_i,
  output logic [MEM_AW-1:0] dm_addr_o,
  input  logic [31:0]       dm_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [31:0]       dump_data_o,
  output logic              dump_is_mem_o,
  output logic [7:0]        dump_idx_o,
  output logic              dump_last_o,
  output logic              done_o
);

  localparam int              CNT_W    = (END_COUNT > 1) ? $clog2(END_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(END_COUNT - 1);
  localparam logic [7:0]      REG_LAST = 8'(NUM_REGS - 1);
  localparam logic [7:0]      MEM_LAST = 8'(NUM_MEM - 1);

  typedef enum logic [2:0] {
    S_COUNT,
    S_REG,
    S_MEM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       index;
  logic             load;

  // A new word may be captured when the output slot is empty or is being
  // emptied on this same edge; this is what keeps REG->MEM bubble-free.
  assign load = !dump_valid_o || dump_ready_i;

  // Read addresses are decoded straight from registered state so the
  // combinational read data is already settled at the capturing edge.
  // NOTE: every always_comb output gets a default first; otherwise paths that
  // skip an assignment would infer a latch.
  always_comb begin
    rf_addr_o = '0;
    dm_addr_o = '0;
    if (state == S_REG) rf_addr_o = index[4:0];
    if (state == S_MEM) dm_addr_o = MEM_AW'({index, 2'b00});
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_COUNT;
      cnt           <= '0;
      index         <= '0;
      cpu_stall_o   <= 1'b0;
      dump_valid_o  <= 1'b0;
      dump_data_o   <= '0;
      dump_is_mem_o <= 1'b0;
      dump_idx_o    <= '0;
      dump_last_o   <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      case (state)
        S_COUNT: begin
          // Counter saturates at END_COUNT-1; that edge starts the freeze.
          if (cnt == CNT_LAST) begin
            state       <= S_REG;
            cpu_stall_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_REG: begin
          if (load) begin
            dump_data_o   <= rf_data_i;
            dump_is_mem_o <= 1'b0;
            dump_idx_o    <= index;
            dump_valid_o  <= 1'b1;
            if (index == REG_LAST) begin
              index <= '0;
              state <= S_MEM;
            end else begin
              index <= index + 8'd1;
            end
          end
        end

        S_MEM: begin
          if (load) begin
            dump_data_o   <= dm_data_i;
            dump_is_mem_o <= 1'b1;
            dump_idx_o    <= index;
            dump_valid_o  <= 1'b1;
            if (index == MEM_LAST) begin
              dump_last_o <= 1'b1;
              state       <= S_DRAIN;
            end else begin
              index <= index + 8'd1;
            end
          end
        end

        S_DRAIN: begin
          // valid is known to be 1 here; wait for the final acceptance.
          if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            done_o       <= 1'b1;
            state        <= S_DONE;
          end
        end

        S_DONE: begin
          // Idle until reset; counter and index stay frozen.
        end

        default: state <= S_COUNT;
      endcase
    end
  end

endmodule
